// File: rtl/mem_bus_responder_pkg.sv
// Shared constants for the CPU data-memory bus responder: MMIO map, TCON bits, and the register decode.
package mem_bus_responder_pkg;

   localparam logic [31:0] MMIO_BASE = 32'h4000_0000;

   localparam logic [7:0] OFF_TH      = 8'h00;
   localparam logic [7:0] OFF_TL      = 8'h04;
   localparam logic [7:0] OFF_TCON    = 8'h08;
   localparam logic [7:0] OFF_LED     = 8'h0C;
   localparam logic [7:0] OFF_DIGITS  = 8'h10;
   localparam logic [7:0] OFF_SYSTICK = 8'h14;

   localparam int TCON_EN = 0;
   localparam int TCON_IE = 1;
   localparam int TCON_IF = 2;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_TH,
      SEL_TL,
      SEL_TCON,
      SEL_LED,
      SEL_DIGITS,
      SEL_SYSTICK
   } mmio_sel_e;

   // The window base is assumed 256-byte aligned, so only the low byte selects a register.
   function automatic mmio_sel_e decode_mmio(input logic [31:0] addr, input logic [31:0] base);
      mmio_sel_e sel;
      sel = SEL_NONE;
      if (addr[31:8] == base[31:8]) begin
         case ({addr[7:2], 2'b00})
            OFF_TH:      sel = SEL_TH;
            OFF_TL:      sel = SEL_TL;
            OFF_TCON:    sel = SEL_TCON;
            OFF_LED:     sel = SEL_LED;
            OFF_DIGITS:  sel = SEL_DIGITS;
            OFF_SYSTICK: sel = SEL_SYSTICK;
            default:     sel = SEL_NONE;
         endcase
      end
      return sel;
   endfunction

endpackage

// File: rtl/mem_bus_responder_timer.sv
// Interval timer: TH reload value, TL up-counter, TCON control/flag, level irq.
module mmio_timer
   import mem_bus_responder_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        we_i,
   input  mmio_sel_e   sel_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] th_o,
   output logic [31:0] tl_o,
   output logic [2:0]  tcon_o,
   output logic        irq_o
);

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic [2:0]  tcon_q, tcon_d;
   logic        cpu_owns;

   // A CPU write to TL or TCON suppresses the whole timer update for that cycle.
   assign cpu_owns = we_i && ((sel_i == SEL_TL) || (sel_i == SEL_TCON));

   always_comb begin
      th_d   = th_q;
      tl_d   = tl_q;
      tcon_d = tcon_q;
      if (tcon_q[TCON_EN] && !cpu_owns) begin
         if (tl_q == 32'hFFFF_FFFF) begin
            tl_d = th_q;
            if (tcon_q[TCON_IE]) tcon_d[TCON_IF] = 1'b1;
         end else begin
            tl_d = tl_q + 32'd1;
         end
      end
      if (we_i) begin
         case (sel_i)
            SEL_TH:   th_d   = wdata_i;
            SEL_TL:   tl_d   = wdata_i;
            SEL_TCON: tcon_d = wdata_i[2:0];
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         th_q   <= '0;
         tl_q   <= '0;
         tcon_q <= '0;
      end else begin
         th_q   <= th_d;
         tl_q   <= tl_d;
         tcon_q <= tcon_d;
      end
   end

   assign th_o   = th_q;
   assign tl_o   = tl_q;
   assign tcon_o = tcon_q;
   assign irq_o  = tcon_q[TCON_IE] & tcon_q[TCON_IF];

endmodule

// File: rtl/mem_bus_responder.sv
// Slave end of the CPU data-memory bus: data RAM plus timer, LED, digit-tube and systick registers.
module mem_bus_responder #(
   parameter int          RAM_WORDS = 512,
   parameter logic [31:0] MMIO_BASE = mem_bus_responder_pkg::MMIO_BASE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] MemBus_Address,
   input  logic [31:0] MemBus_Write_Data,
   output logic [31:0] Device_Read_Data,
   output logic [7:0]  leds,
   output logic [11:0] digits,
   output logic        irq
);

   import mem_bus_responder_pkg::*;

   localparam int AW = $clog2(RAM_WORDS);

   // Bus strobes: no handshake. A read is answered combinationally in the cycle MemRead is high;
   // a write commits at the edge closing the cycle in which MemWrite is high. Both may be high at once.
   logic          ram_hit;
   logic [AW-1:0] ram_idx;
   mmio_sel_e     mmio_sel;

   assign ram_hit  = (MemBus_Address[31:AW+2] == '0);
   assign ram_idx  = MemBus_Address[AW+1:2];
   assign mmio_sel = ram_hit ? SEL_NONE : decode_mmio(MemBus_Address, MMIO_BASE);

   logic [31:0] ram_q [RAM_WORDS];

   always_ff @(posedge clk) begin
      if (MemWrite && ram_hit) ram_q[ram_idx] <= MemBus_Write_Data;
   end

   logic [7:0]  led_q, led_d;
   logic [11:0] digits_q, digits_d;
   logic [31:0] systick_q, systick_d;

   always_comb begin
      led_d     = led_q;
      digits_d  = digits_q;
      systick_d = systick_q + 32'd1;
      if (MemWrite) begin
         case (mmio_sel)
            SEL_LED:    led_d    = MemBus_Write_Data[7:0];
            SEL_DIGITS: digits_d = MemBus_Write_Data[11:0];
            default:    ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led_q     <= '0;
         digits_q  <= '0;
         systick_q <= '0;
      end else begin
         led_q     <= led_d;
         digits_q  <= digits_d;
         systick_q <= systick_d;
      end
   end

   logic [31:0] th_w, tl_w;
   logic [2:0]  tcon_w;

   mmio_timer u_timer (
      .clk_i   (clk),
      .reset_i (reset),
      .we_i    (MemWrite),
      .sel_i   (mmio_sel),
      .wdata_i (MemBus_Write_Data),
      .th_o    (th_w),
      .tl_o    (tl_w),
      .tcon_o  (tcon_w),
      .irq_o   (irq)
   );

   always_comb begin
      Device_Read_Data = '0;
      if (MemRead) begin
         if (ram_hit) begin
            Device_Read_Data = ram_q[ram_idx];
         end else begin
            case (mmio_sel)
               SEL_TH:      Device_Read_Data = th_w;
               SEL_TL:      Device_Read_Data = tl_w;
               SEL_TCON:    Device_Read_Data = {29'd0, tcon_w};
               SEL_LED:     Device_Read_Data = {24'd0, led_q};
               SEL_DIGITS:  Device_Read_Data = {20'd0, digits_q};
               SEL_SYSTICK: Device_Read_Data = systick_q;
               default:     Device_Read_Data = '0;
            endcase
         end
      end
   end

   assign leds   = led_q;
   assign digits = digits_q;

endmodule
